regfile_wb_arb: RTL and testbench

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/regfile_wb_arb.sv | 85 ++++++++
 tb/tb_regfile_wb_arb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file writeback path.
// wb_req_t is sized for the largest supported configuration; users slice it down.
package regfile_pkg;

    localparam int CONFLICT_CNT_W = 16;
    localparam int WB_MAX_AW      = 16;
    localparam int WB_MAX_DW      = 64;

    typedef struct packed {
        logic [WB_MAX_AW-1:0] addr;
        logic [WB_MAX_DW-1:0] data;
    } wb_req_t;

    function automatic int calcAw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant, pointer advances past the winner.
// The scan starts at the pointer and wraps modulo N; en low suppresses all grants.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            idx;
    int            gntIdx;

    always_comb begin
        gnt    = '0;
        ptr_d  = ptr_q;
        found  = 1'b0;
        idx    = 0;
        gntIdx = 0;
        if (en) begin
            for (int off = 0; off < N; off++) begin
                idx = (int'(ptr_q) + off) % N;
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                    gntIdx   = idx;
                end
            end
        end
        if (found) begin
            ptr_d = (gntIdx == N - 1) ? '0 : PW'(gntIdx + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arb.sv
// Round-robin writeback arbiter feeding a single register-file write port.
// Optional macro REGFILE_WB_ZERO_REG_EN: writes to address 0 are granted but not enabled.
module regfile_wb_arb
    import regfile_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_REG = 32,
    parameter  int N_SRC = 4,
    localparam int AW    = calcAw(N_REG)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_SRC-1:0]                src_valid,
    input  logic [N_SRC-1:0][AW-1:0]        src_addr,
    input  logic [N_SRC-1:0][WIDTH-1:0]     src_data,
    output logic [N_SRC-1:0]                src_ready,
    output logic                            wen,
    output logic [AW-1:0]                   waddr,
    output logic [WIDTH-1:0]                wdata,
    output logic [CONFLICT_CNT_W-1:0]       conflict_cnt
);

    logic [N_SRC-1:0]          gnt;
    logic                      granted;
    logic                      multiReq;
    wb_req_t                   selReq;
    wb_req_t                   req_q;
    wb_req_t                   req_d;
    logic                      wen_q;
    logic                      wen_d;
    logic [CONFLICT_CNT_W-1:0] cnt_q;
    logic [CONFLICT_CNT_W-1:0] cnt_d;

    rr_arbiter #(
        .N   (N_SRC)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (src_valid),
        .en  (~rst),
        .gnt (gnt)
    );

    always_comb begin
        selReq = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt[i]) begin
                selReq.addr = WB_MAX_AW'(src_addr[i]);
                selReq.data = WB_MAX_DW'(src_data[i]);
            end
        end
    end

    // Address and data hold between grants; only wen drops when idle.
    always_comb begin
        granted  = |gnt;
        multiReq = ($countones(src_valid) >= 2);
`ifdef REGFILE_WB_ZERO_REG_EN
        wen_d    = granted && (selReq.addr != '0);
`else
        wen_d    = granted;
`endif
        req_d    = granted ? selReq : req_q;
        cnt_d    = (multiReq && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q <= 1'b0;
            req_q <= '0;
            cnt_q <= '0;
        end else begin
            wen_q <= wen_d;
            req_q <= req_d;
            cnt_q <= cnt_d;
        end
    end

    assign src_ready    = gnt;
    assign wen          = wen_q;
    assign waddr        = req_q.addr[AW-1:0];
    assign wdata        = req_q.data[WIDTH-1:0];
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Scoreboard bench for regfile_wb_arb: a reference model predicts each cycle's grant
// and queues the write expected one cycle later; the queue is drained after each edge.
module tb_regfile_wb_arb;

    localparam int WIDTH = 32;
    localparam int N_REG = 32;
    localparam int N_SRC = 4;
    localparam int AW    = 5;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [N_SRC-1:0]            src_valid;
    logic [N_SRC-1:0][AW-1:0]    src_addr;
    logic [N_SRC-1:0][WIDTH-1:0] src_data;
    logic [N_SRC-1:0]            src_ready;
    logic                        wen;
    logic [AW-1:0]               waddr;
    logic [WIDTH-1:0]            wdata;
    logic [15:0]                 conflict_cnt;

    typedef struct {
        logic             wen;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic [15:0]      cnt;
    } expWrite_t;

    expWrite_t expQ[$];

    int errorCount = 0;
    int checkCount = 0;

    int               mPtr  = 0;
    logic             mWen  = 1'b0;
    logic [AW-1:0]    mAddr = '0;
    logic [WIDTH-1:0] mData = '0;
    logic [15:0]      mCnt  = '0;

    regfile_wb_arb #(
        .WIDTH        (WIDTH),
        .N_REG        (N_REG),
        .N_SRC        (N_SRC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_addr     (src_addr),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drives one cycle: predicts grant, checks src_ready mid-cycle, then checks the
    // registered write just after the clock edge against the queued prediction.
    task automatic applyStimulus(input logic rstV, input logic [N_SRC-1:0] valid,
                                 input logic [N_SRC-1:0][AW-1:0] addrs,
                                 input logic [N_SRC-1:0][WIDTH-1:0] datas);
        logic [N_SRC-1:0] expGnt;
        int               gi;
        bit               found;
        expWrite_t        e;
        expWrite_t        got;

        rst       = rstV;
        src_valid = valid;
        src_addr  = addrs;
        src_data  = datas;

        expGnt = '0;
        gi     = 0;
        found  = 0;
        if (!rstV) begin
            for (int k = 0; k < N_SRC; k++) begin
                int c;
                c = (mPtr + k) % N_SRC;
                if (!found && valid[c]) begin
                    expGnt[c] = 1'b1;
                    gi        = c;
                    found     = 1;
                end
            end
        end

        @(negedge clk);
        checkOutput("src_ready", 32'(src_ready), 32'(expGnt));

        if (rstV) begin
            mPtr  = 0;
            mWen  = 1'b0;
            mAddr = '0;
            mData = '0;
            mCnt  = '0;
        end else begin
            if ($countones(valid) >= 2 && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
            if (found) begin
                mPtr  = (gi + 1) % N_SRC;
                mAddr = addrs[gi];
                mData = datas[gi];
`ifdef REGFILE_WB_ZERO_REG_EN
                mWen  = (addrs[gi] != '0);
`else
                mWen  = 1'b1;
`endif
            end else begin
                mWen = 1'b0;
            end
        end
        e.wen  = mWen;
        e.addr = mAddr;
        e.data = mData;
        e.cnt  = mCnt;
        expQ.push_back(e);

        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = expQ.pop_front();
            checkOutput("wen", 32'(wen), 32'(got.wen));
            checkOutput("waddr", 32'(waddr), 32'(got.addr));
            checkOutput("wdata", wdata, got.data);
            checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(got.cnt));
        end
    endtask

    task automatic idleCycle(input logic rstV);
        applyStimulus(rstV, '0, '0, '0);
    endtask

    initial begin
        logic [N_SRC-1:0][AW-1:0]    a;
        logic [N_SRC-1:0][WIDTH-1:0] d;

        rst       = 1'b1;
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
        @(posedge clk);
        #1;

        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("reset_wen", 32'(wen), 32'd0);
        checkOutput("reset_cnt", 32'(conflict_cnt), 32'd0);

        // Single source write, latency one.
        a = '0; d = '0;
        a[0] = 5'd5; d[0] = 32'hAA;
        applyStimulus(1'b0, 4'b0001, a, d);
        checkOutput("single_wen", 32'(wen), 32'd1);
        checkOutput("single_waddr", 32'(waddr), 32'd5);
        checkOutput("single_wdata", wdata, 32'hAA);
        idleCycle(1'b0);

        // All sources held valid: rotating grants, conflicts counted.
        idleCycle(1'b1);
        for (int i = 0; i < N_SRC; i++) begin
            a[i] = 5'(i + 10);
            d[i] = 32'(32'h100 + i);
        end
        for (int n = 0; n < 8; n++) applyStimulus(1'b0, 4'b1111, a, d);
        checkOutput("full_cnt8", 32'(conflict_cnt), 32'd8);
        idleCycle(1'b0);

        // Same destination from two sources, written in grant order.
        a = '0; d = '0;
        a[1] = 5'd7; d[1] = 32'h11;
        a[3] = 5'd7; d[3] = 32'h33;
        applyStimulus(1'b0, 4'b1010, a, d);
        checkOutput("same_addr_first", wdata, 32'h11);
        applyStimulus(1'b0, 4'b1000, a, d);
        checkOutput("same_addr_second", wdata, 32'h33);
        idleCycle(1'b0);

        // Reset just after a grant drops the pipeline and pointer.
        for (int i = 0; i < N_SRC; i++) begin
            a[i] = 5'(i + 20);
            d[i] = 32'(32'hC0 + i);
        end
        applyStimulus(1'b0, 4'b0100, a, d);
        applyStimulus(1'b1, 4'b1111, a, d);
        checkOutput("rst_pulse_wen", 32'(wen), 32'd0);
        applyStimulus(1'b0, 4'b1111, a, d);
        checkOutput("rst_pulse_src0", 32'(waddr), 32'd20);
        idleCycle(1'b0);

        // Address zero write.
        a = '0; d = '0;
        d[0] = 32'h55;
        applyStimulus(1'b0, 4'b0001, a, d);
`ifdef REGFILE_WB_ZERO_REG_EN
        checkOutput("zero_reg_wen", 32'(wen), 32'd0);
`else
        checkOutput("zero_reg_wen", 32'(wen), 32'd1);
`endif
        checkOutput("zero_reg_waddr", 32'(waddr), 32'd0);
        idleCycle(1'b0);

        // Random mix.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N_SRC; i++) begin
                a[i] = 5'($urandom_range(0, 31));
                d[i] = $urandom;
            end
            applyStimulus(1'b0, 4'($urandom_range(0, 15)), a, d);
        end

        // Saturation of the conflict counter.
        idleCycle(1'b1);
        for (int i = 0; i < N_SRC; i++) begin
            a[i] = 5'(i + 1);
            d[i] = 32'(i);
        end
        for (int n = 0; n < 65535; n++) applyStimulus(1'b0, 4'b1111, a, d);
        checkOutput("cnt_at_max", 32'(conflict_cnt), 32'hFFFF);
        applyStimulus(1'b0, 4'b0011, a, d);
        checkOutput("cnt_saturated", 32'(conflict_cnt), 32'hFFFF);
        idleCycle(1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
